// File: rtl/ping_pong_sequencer_if.sv
// Counter-side bundle between the sequencer and one ping-pong counter.
// The sequencer is the master; the counter is the slave.
interface ping_pong_sequencer_if;
  logic       cnt_rst_n;
  logic       cnt_enable;
  logic       cnt_flip;
  logic [3:0] cnt_min;
  logic [3:0] cnt_max;
  logic [3:0] cnt_out;
  logic       cnt_dir;

  modport master (
    output cnt_rst_n,
    output cnt_enable,
    output cnt_flip,
    output cnt_min,
    output cnt_max,
    input  cnt_out,
    input  cnt_dir
  );

  modport slave (
    input  cnt_rst_n,
    input  cnt_enable,
    input  cnt_flip,
    input  cnt_min,
    input  cnt_max,
    output cnt_out,
    output cnt_dir
  );
endinterface

// File: rtl/ping_pong_sequencer.sv
// Sequences a ping-pong counter through a table of count windows.
// Each window runs a number of round trips between its min and max.
module ping_pong_sequencer #(
  parameter  int NUM_WIN = 4,
  localparam int IW      = $clog2(NUM_WIN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [IW-1:0]           cfg_addr,
  input  logic [3:0]              cfg_min,
  input  logic [3:0]              cfg_max,
  input  logic [3:0]              cfg_trips,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    flip_req,
  ping_pong_sequencer_if.master   cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [IW-1:0]           win_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   win_idx_q, win_idx_d;
  logic [3:0]      trip_cnt_q, trip_cnt_d;
  logic            err_q, err_d;

  logic [3:0]      min_q   [NUM_WIN];
  logic [3:0]      min_d   [NUM_WIN];
  logic [3:0]      max_q   [NUM_WIN];
  logic [3:0]      max_d   [NUM_WIN];
  logic [3:0]      trips_q [NUM_WIN];
  logic [3:0]      trips_d [NUM_WIN];

  logic [3:0]      cur_min;
  logic [3:0]      cur_max;
  logic [3:0]      cur_trips;
  logic            last_win;
  logic            round_trip;
  logic [4:0]      trip_nxt;

  assign cur_min    = min_q[win_idx_q];
  assign cur_max    = max_q[win_idx_q];
  assign cur_trips  = trips_q[win_idx_q];
  assign last_win   = (win_idx_q == IW'(NUM_WIN - 1));
  assign round_trip = (cnt.cnt_out == cur_min) && cnt.cnt_dir;
  assign trip_nxt   = {1'b0, trip_cnt_q} + 5'd1;

  // Next-state, window/trip bookkeeping and table writes.
  always_comb begin
    state_d    = state_q;
    win_idx_d  = win_idx_q;
    trip_cnt_d = trip_cnt_q;
    err_d      = err_q;
    min_d      = min_q;
    max_d      = max_q;
    trips_d    = trips_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_we) begin
          min_d[cfg_addr]   = cfg_min;
          max_d[cfg_addr]   = cfg_max;
          trips_d[cfg_addr] = cfg_trips;
        end
        if (start) begin
          win_idx_d = '0;
          err_d     = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        trip_cnt_d = '0;
        if (cur_max <= cur_min) begin
          err_d   = 1'b1;
          state_d = S_NEXT;
        end else if (cur_trips == 4'd0) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (round_trip) begin
          if (trip_nxt == {1'b0, cur_trips}) begin
            state_d = S_NEXT;
          end else begin
            trip_cnt_d = trip_nxt[3:0];
          end
        end
      end
      S_NEXT: begin
        if (last_win) begin
          state_d = S_DONE;
        end else begin
          win_idx_d = win_idx_q + IW'(1);
          state_d   = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort overrides everything and freezes err/win_idx
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      win_idx_d  = win_idx_q;
      trip_cnt_d = trip_cnt_q;
      err_d      = err_q;
    end
  end

  // State, window, trip counter and table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      win_idx_q  <= '0;
      trip_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_WIN; i++) begin
        min_q[i]   <= 4'd0;
        max_q[i]   <= 4'd15;
        trips_q[i] <= 4'd1;
      end
    end else begin
      state_q    <= state_d;
      win_idx_q  <= win_idx_d;
      trip_cnt_q <= trip_cnt_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_WIN; i++) begin
        min_q[i]   <= min_d[i];
        max_q[i]   <= max_d[i];
        trips_q[i] <= trips_d[i];
      end
    end
  end

  assign cnt.cnt_rst_n  = (state_q != S_LOAD);
  assign cnt.cnt_enable = (state_q == S_RUN);
  assign cnt.cnt_flip   = (state_q == S_RUN) && flip_req;
  assign cnt.cnt_min    = cur_min;
  assign cnt.cnt_max    = cur_max;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err            = err_q;
  assign win_idx        = win_idx_q;

endmodule

// File: doc/ping_pong_sequencer.md
# ping_pong_sequencer

Controller that sequences one parameterized ping-pong counter through a programmable table of four count windows. Each window has its own min, max and round-trip count. The block drives the counter's enable, flip, max, min and synchronous reset, and watches the counter's out and direction to decide when a window is finished. It sits between the lab top level (buttons/switches) and the counter instance.

## Interface
- NUM_WIN, 4: table depth; win_idx width is log2(NUM_WIN).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write table[cfg_addr] this cycle; ignored while busy.
- cfg_addr  in  2  table entry index.
- cfg_min  in  4  window lower bound.
- cfg_max  in  4  window upper bound.
- cfg_trips  in  4  round trips to run in the window; 0 skips the window.
- start  in  1  begin sequence; sampled only in IDLE.
- abort  in  1  stop the sequence; returns to IDLE.
- flip_req  in  1  user flip; forwarded to the counter only in RUN.
- cnt_out  in  4  counter value.
- cnt_dir  in  1  counter direction (0 = up, 1 = down).
- cnt_rst_n  out  1  synchronous load request to the counter; low for one cycle in LOAD.
- cnt_enable  out  1  high only in RUN.
- cnt_flip  out  1  equals flip_req in RUN, else 0.
- cnt_min  out  4  table[win_idx].min.
- cnt_max  out  4  table[win_idx].max.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  sticky; set when a window has max <= min.
- win_idx  out  2  current window.

## Operation
- Table reset value for every entry: min = 0, max = 15, trips = 1.
- On cfg_we in IDLE, all three fields of the addressed entry are written at the clock edge.
- FSM states: IDLE, LOAD, RUN, NEXT, DONE. Outputs are Moore, decoded from the state and registers.
- IDLE:
  - With start = 1: win_idx = 0, err = 0, go to LOAD.
- LOAD (1 cycle):
  - cnt_rst_n = 0, so the counter loads cnt_min with dir 0.
  - trip_cnt = 0.
  - If the entry has max <= min: set err, go to NEXT.
  - Else if trips = 0: go to NEXT (no error).
  - Else: go to RUN.
- RUN:
  - cnt_enable = 1.
  - A round trip is a RUN cycle where cnt_out == cnt_min and cnt_dir == 1. A flip at that point does not change detection.
  - On a round trip: if trip_cnt + 1 == trips, go to NEXT; else increment trip_cnt.
  - The counter advances one step on that same edge. This is accepted.
- NEXT (1 cycle):
  - If win_idx == NUM_WIN-1, go to DONE.
  - Else increment win_idx and go to LOAD.
- DONE (1 cycle): done = 1, go to IDLE. win_idx holds its value.
- abort in LOAD, RUN, NEXT or DONE:
  - Next state is IDLE; no done pulse.
  - err and win_idx hold their values.
  - abort takes priority over every other transition.
- start while busy is ignored. cfg_we while busy is ignored.
- Async reset in mid-operation: state goes to IDLE and the table returns to its reset values.
- Outputs under reset:
  - cnt_enable, cnt_flip, busy, done, err all 0.
  - cnt_rst_n = 1, win_idx = 0.
  - cnt_min = 0, cnt_max = 15.

## Timing
- start sampled at edge E0: LOAD occupies cycle E0–E1. The counter holds cnt_min at E1. RUN begins after E1.
- Window of span S = max - min with T trips: RUN lasts 2·S·T + 1 cycles. The counter value at the end of RUN is min + 1.
- Per-window overhead: LOAD 1 cycle + NEXT 1 cycle. A skipped or errored window costs 2 cycles.
- done is asserted the cycle after NEXT for the last window. busy drops the cycle after done.
- abort asserted at an edge: cnt_enable is low in the following cycle.

## Test plan
- Program windows {2,5,1}, {0,3,2}, {7,7,1}, {1,2,0}, then start. Required:
  - Window 0: counter 2,3,4,5,4,3,2 with RUN = 7 cycles.
  - Window 1: RUN = 13 cycles.
  - Window 2: err = 1.
  - Window 3: skipped.
  - done pulses once; total start-to-done = 29 cycles.
- Default table, start. Required: 4 windows of RUN = 31 cycles each; done; err = 0.
- Window {4,9,3}, flip_req pulsed at cnt_out = 6 going up. Required:
  - The counter reverses.
  - The round trip is counted at the 4-with-dir-1 cycle.
  - The window still ends after 3 round trips.
- abort on the 5th RUN cycle of window 1. Required:
  - cnt_enable = 0 next cycle, busy = 0, no done, win_idx = 1.
  - A new start begins at window 0 with err cleared.
- cfg_we while busy to entry 0 with {0,1,1}. Required: the table is unchanged; the next run uses the original entry.
- rst_n low mid-RUN. Required: outputs take their reset values immediately (asynchronous); the table is back to {0,15,1}.
